// File: rtl/riscv_multi_ctrl.sv
// riscv_multi_ctrl -- multicycle control unit for the RISC-V core.
// Sequences a unified-memory, single-ALU datapath through fetch, decode,
// execute, memory and writeback steps, driving every datapath select and
// write enable from the current state and the latched instruction.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (forces FETCH, masks writes)
//   instr      instruction register output
//   zero       ALU zero flag (used only in BRANCH)
//   pc_we      PC write               adr_src   0=PC, 1=result bus
//   mem_we     memory write           ir_we     IR / old-PC write
//   res_src    0=ALU-out, 1=mem data, 2=live ALU result
//   alu_src_a  0=PC, 1=old PC, 2=rs1
//   alu_src_b  0=rs2, 1=imm, 2=const 4
//   imm_src    0=I, 1=S, 2=B, 3=J
//   alu_ctrl   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLL,7 SRL,8 SRA
//   reg_we     register-file write
//   state      current state (debug)
`timescale 1ns/1ps
module riscv_multi_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_we,
    output logic        adr_src,
    output logic        mem_we,
    output logic        ir_we,
    output logic [1:0]  res_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic        reg_we,
    output logic [3:0]  state
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_JAL     = 4'd9,
        S_BRANCH  = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                           ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8;

    state_t      state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        pc_we_raw, mem_we_raw, ir_we_raw, reg_we_raw;
    logic        unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7b5     = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign state        = state_q;

    // Funct decode for EXEC_R / EXEC_I. Only R-type can select SUB; an
    // I-type with bit 30 set (negative immediate) is still an add.
    function automatic logic [3:0] funct_op(input logic [2:0] f3,
                                            input logic f7b5,
                                            input logic is_r);
        case (f3)
            3'b000:  funct_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_op = ALU_SLL;
            3'b010:  funct_op = ALU_SLT;
            3'b100:  funct_op = ALU_XOR;
            3'b101:  funct_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  funct_op = ALU_OR;
            3'b111:  funct_op = ALU_AND;
            default: funct_op = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = S_MEM_WB;
            S_EXEC_R:  state_d = S_ALU_WB;
            S_EXEC_I:  state_d = S_ALU_WB;
            S_JAL:     state_d = S_ALU_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_we_raw  = 1'b0;
        adr_src    = 1'b0;
        mem_we_raw = 1'b0;
        ir_we_raw  = 1'b0;
        res_src    = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_ctrl   = ALU_ADD;
        reg_we_raw = 1'b0;
        case (opcode)
            OP_STORE:  imm_src = 3'd1;
            OP_BRANCH: imm_src = 3'd2;
            OP_JAL:    imm_src = 3'd3;
            default:   imm_src = 3'd0;
        endcase
        case (state_q)
            S_FETCH: begin
                ir_we_raw = 1'b1;
                pc_we_raw = 1'b1;
                alu_src_b = 2'd2;
                res_src   = 2'd2;
            end
            S_DECODE: begin
                // Precompute PC-relative target into ALU-out.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            S_MEM_ADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
            end
            S_MEM_RD: adr_src = 1'b1;
            S_MEM_WB: begin
                res_src    = 2'd1;
                reg_we_raw = 1'b1;
            end
            S_MEM_WR: begin
                adr_src    = 1'b1;
                mem_we_raw = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_ctrl  = funct_op(funct3, funct7b5, 1'b1);
            end
            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_ctrl  = funct_op(funct3, funct7b5, 1'b0);
            end
            S_ALU_WB: reg_we_raw = 1'b1;
            S_JAL: begin
                // PC <- target in ALU-out while ALU forms old PC + 4 for rd.
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_we_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_ctrl  = ALU_SUB;
                // funct3[0] flips the sense: beq takes on zero, bne on !zero.
                // funct3[2:1] must be 00, otherwise the PC is never written.
                pc_we_raw = (funct3[2:1] == 2'b00) && (zero ^ funct3[0]);
            end
            default: ;
        endcase
    end

    // Writes are masked combinationally so a write pending at the edge
    // where reset rises is dropped.
    assign pc_we  = pc_we_raw  & ~rst;
    assign mem_we = mem_we_raw & ~rst;
    assign ir_we  = ir_we_raw  & ~rst;
    assign reg_we = reg_we_raw & ~rst;
endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// tb_riscv_multi_ctrl -- scoreboard bench for riscv_multi_ctrl.
// Expected per-cycle output vectors are pushed when an instruction is
// queued, then popped and compared once per cycle mid-period.
`timescale 1ns/1ps
module tb_riscv_multi_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0064a423;
    logic        zero = 1'b0;
    logic        pc_we, adr_src, mem_we, ir_we, reg_we;
    logic [1:0]  res_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl, state;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sb_q[$];
    string       tag_q[$];

    riscv_multi_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pc_we(pc_we), .adr_src(adr_src), .mem_we(mem_we), .ir_we(ir_we),
        .res_src(res_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_ctrl(alu_ctrl), .reg_we(reg_we),
        .state(state)
    );

    always #5 clk = ~clk;

    // Field order: st pc adr mem ir res a b imm alu reg
    function automatic logic [31:0] pk(input int st, input int pc, input int adr,
                                       input int mem, input int ir, input int res,
                                       input int a, input int b, input int imm,
                                       input int alu, input int rg);
        logic [31:0] v;
        v = '0;
        v[21:18] = st[3:0];
        v[17]    = pc[0];
        v[16]    = adr[0];
        v[15]    = mem[0];
        v[14]    = ir[0];
        v[13:12] = res[1:0];
        v[11:10] = a[1:0];
        v[9:8]   = b[1:0];
        v[7:5]   = imm[2:0];
        v[4:1]   = alu[3:0];
        v[0]     = rg[0];
        return v;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {10'd0, state, pc_we, adr_src, mem_we, ir_we, res_src,
                alu_src_a, alu_src_b, imm_src, alu_ctrl, reg_we};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk();
        logic [31:0] e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk(t, dut_vec(), e);
    endtask

    // Common leading cycles.
    task automatic push_fd(input string nm, input int imm);
        push({nm, "_fetch"},  pk(0, 1, 0, 0, 1, 2, 0, 2, imm, 0, 0));
        push({nm, "_decode"}, pk(1, 0, 0, 0, 0, 0, 1, 1, imm, 0, 0));
    endtask

    // Pops n scoreboard entries (all if n<0), one per clock, sampled 3ns
    // after the edge. Entered and left 2ns after a rising edge.
    task automatic run(input logic [31:0] ins, input logic z, input int n);
        int k;
        instr = ins;
        zero  = z;
        k = 0;
        while (sb_q.size() > 0 && (n < 0 || k < n)) begin
            #1;
            pop_chk();
            @(posedge clk);
            #2;
            k++;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: writes masked, FETCH selects, imm decoded from sw (S).
        #3;
        push("reset_hold", pk(0, 0, 0, 0, 0, 2, 0, 2, 1, 0, 0));
        pop_chk();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // lw x6,-4(x9)
        push_fd("lw", 0);
        push("lw_madr", pk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("lw_mrd",  pk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push("lw_mwb",  pk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        run(32'hffc4a303, 1'b0, -1);

        // sw x6,8(x9)
        push_fd("sw", 1);
        push("sw_madr", pk(2, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0));
        push("sw_mwr",  pk(5, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        run(32'h0064a423, 1'b0, -1);

        // sub x4,x5,x6
        push_fd("sub", 0);
        push("sub_exec", pk(6, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0));
        push("sub_wb",   pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run(32'h40628233, 1'b0, -1);

        // or x4,x5,x6
        push_fd("or", 0);
        push("or_exec", pk(6, 0, 0, 0, 0, 0, 2, 0, 0, 3, 0));
        push("or_wb",   pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run(32'h0062e233, 1'b0, -1);

        // srai x1,x1,1 -> SRA
        push_fd("srai", 0);
        push("srai_exec", pk(7, 0, 0, 0, 0, 0, 2, 1, 0, 8, 0));
        push("srai_wb",   pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run(32'h4010d093, 1'b0, -1);

        // addi x1,x0,-1: bit 30 set but I-type stays ADD
        push_fd("addi", 0);
        push("addi_exec", pk(7, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("addi_wb",   pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run(32'hfff00093, 1'b0, -1);

        // jal x1,8
        push_fd("jal", 3);
        push("jal_jal", pk(9, 1, 0, 0, 0, 0, 1, 2, 3, 0, 0));
        push("jal_wb",  pk(8, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1));
        run(32'h008000ef, 1'b0, -1);

        // beq / bne with both zero values
        push_fd("beq_z1", 2);
        push("beq_z1_br", pk(10, 1, 0, 0, 0, 0, 2, 0, 2, 1, 0));
        run(32'hfe420ae3, 1'b1, -1);
        push_fd("beq_z0", 2);
        push("beq_z0_br", pk(10, 0, 0, 0, 0, 0, 2, 0, 2, 1, 0));
        run(32'hfe420ae3, 1'b0, -1);
        push_fd("bne_z1", 2);
        push("bne_z1_br", pk(10, 0, 0, 0, 0, 0, 2, 0, 2, 1, 0));
        run(32'hfe421ae3, 1'b1, -1);
        push_fd("bne_z0", 2);
        push("bne_z0_br", pk(10, 1, 0, 0, 0, 0, 2, 0, 2, 1, 0));
        run(32'hfe421ae3, 1'b0, -1);

        // Illegal opcode: FETCH, DECODE, back to FETCH
        push_fd("ill", 0);
        run(32'h0000007f, 1'b0, -1);
        push("ill_back", pk(0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
        #1;
        pop_chk();

        // Reset pulse in MEM_RD of a load: no MEM_WB write follows.
        #1;
        push_fd("rlw", 0);
        push("rlw_madr", pk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("rlw_mrd",  pk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run(32'hffc4a303, 1'b0, 3);
        #1;
        pop_chk();
        rst = 1'b1;
        #0.001;
        push("rlw_in_rst", pk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        pop_chk();
        #0.002;
        rst = 1'b0;
        #0.001;
        push("rlw_after", pk(0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
        pop_chk();
        @(posedge clk);
        #2;
        push("rlw2_decode", pk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        push("rlw2_madr",   pk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("rlw2_mrd",    pk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push("rlw2_mwb",    pk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        push("rlw2_fetch",  pk(0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
        run(32'hffc4a303, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
